// File: rtl/fifo_write_packer.sv
// Packs RATIO narrow beats into one FIFO word and writes it into fifo_async_circular (WCLK domain).
// Optional PACK_STATS_EN adds saturating word/pad counters (WORD_CNT, PAD_CNT).
module fifo_write_packer #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                         WCLK,
  input  logic                         WNRST,
  input  logic                         S_VALID,
  output logic                         S_READY,
  input  logic [IN_WIDTH-1:0]          S_DATA,
  input  logic                         S_LAST,
  input  logic                         FULL,
  output logic                         W_EN,
  output logic [IN_WIDTH*RATIO-1:0]    W_DI
`ifdef PACK_STATS_EN
  ,
  output logic [15:0]                  WORD_CNT,
  output logic [15:0]                  PAD_CNT
`endif
);

  localparam int unsigned OutW  = IN_WIDTH * RATIO;
  localparam int unsigned LaneW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LaneW-1:0] LaneMax = LaneW'(RATIO - 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  logic [OutW-1:0]  asm_q, asm_d, asm_merged;
  logic [OutW-1:0]  hold_q, hold_d;
  logic [LaneW-1:0] lane_q, lane_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             hold_v_q, hold_v_d;
  logic             accept, complete, flush;

  assign W_EN    = hold_v_q & ~FULL;
  assign S_READY = ~hold_v_q | ~FULL;
  assign W_DI    = hold_q;

  assign accept   = S_VALID & S_READY;
  assign complete = accept & ((lane_q == LaneMax) | S_LAST);
  // Flush only when the hold is free (empty or draining), which is exactly S_READY.
  assign flush    = (TIMEOUT > 0) && (lane_q != '0) && !accept && (idle_q == IdleMax) && S_READY;

  always_comb begin
    asm_merged = asm_q;
    asm_merged[lane_q*IN_WIDTH +: IN_WIDTH] = S_DATA;

    asm_d    = asm_q;
    lane_d   = lane_q;
    idle_d   = idle_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;

    if (W_EN) hold_v_d = 1'b0;

    if (complete) begin
      // Higher lanes of asm_q are always zero, so the merge is already zero-padded.
      hold_d   = asm_merged;
      hold_v_d = 1'b1;
      asm_d    = '0;
      lane_d   = '0;
      idle_d   = '0;
    end else if (accept) begin
      asm_d  = asm_merged;
      lane_d = lane_q + 1'b1;
      idle_d = '0;
    end else if (flush) begin
      hold_d   = asm_q;
      hold_v_d = 1'b1;
      asm_d    = '0;
      lane_d   = '0;
      idle_d   = '0;
    end else if ((TIMEOUT > 0) && (lane_q != '0) && (idle_q != IdleMax)) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge WCLK or posedge WNRST) begin
    if (WNRST) begin
      asm_q    <= '0;
      lane_q   <= '0;
      idle_q   <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      lane_q   <= lane_d;
      idle_q   <= idle_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
  end

`ifdef PACK_STATS_EN
  logic [15:0] word_cnt_q, pad_cnt_q;
  logic        partial_load;

  assign partial_load = (complete & (lane_q != LaneMax)) | flush;

  always_ff @(posedge WCLK or posedge WNRST) begin
    if (WNRST) begin
      word_cnt_q <= '0;
      pad_cnt_q  <= '0;
    end else begin
      if (W_EN && (word_cnt_q != 16'hFFFF)) word_cnt_q <= word_cnt_q + 16'd1;
      if (partial_load && (pad_cnt_q != 16'hFFFF)) pad_cnt_q <= pad_cnt_q + 16'd1;
    end
  end

  assign WORD_CNT = word_cnt_q;
  assign PAD_CNT  = pad_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_packer.sv
// Self-checking bench for fifo_write_packer: directed scenarios plus randomized frames
// checked against a word-level packing model.
module tb_fifo_write_packer;

  localparam int unsigned IW    = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned TO    = 8;
  localparam int unsigned OW    = IW * RATIO;

  logic          WCLK = 1'b0;
  logic          WNRST = 1'b1;
  logic          S_VALID = 1'b0;
  logic          S_LAST = 1'b0;
  logic          FULL = 1'b0;
  logic [IW-1:0] S_DATA = '0;
  logic          S_READY;
  logic          W_EN;
  logic [OW-1:0] W_DI;
`ifdef PACK_STATS_EN
  logic [15:0]   WORD_CNT, PAD_CNT;
`endif

  fifo_write_packer #(
    .IN_WIDTH (IW),
    .RATIO    (RATIO),
    .TIMEOUT  (TO)
  ) dut (
    .WCLK     (WCLK),
    .WNRST    (WNRST),
    .S_VALID  (S_VALID),
    .S_READY  (S_READY),
    .S_DATA   (S_DATA),
    .S_LAST   (S_LAST),
    .FULL     (FULL),
    .W_EN     (W_EN),
    .W_DI     (W_DI)
`ifdef PACK_STATS_EN
    ,
    .WORD_CNT (WORD_CNT),
    .PAD_CNT  (PAD_CNT)
`endif
  );

  always #5 WCLK = ~WCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [OW-1:0] got_data[$];
  int            got_cyc[$];

  always @(posedge WCLK) cyc <= cyc + 1;

  // Every cycle with W_EN high is one FIFO write.
  always @(negedge WCLK) begin
    if (!WNRST && W_EN) begin
      got_data.push_back(W_DI);
      got_cyc.push_back(cyc);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge WCLK);
    #1;
  endtask

  task automatic clear_log();
    got_data.delete();
    got_cyc.delete();
  endtask

  // Presents one beat until accepted; returns 1 time unit after the accepting edge.
  task automatic drive_beat(input logic [IW-1:0] d, input logic last);
    int n = 0;
    S_VALID = 1'b1;
    S_DATA  = d;
    S_LAST  = last;
    @(negedge WCLK);
    while (!S_READY && n < 200) begin
      @(negedge WCLK);
      n++;
    end
    if (!S_READY) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: S_READY stuck at %0b, required 1 within 200 cycles", S_READY);
    end
    @(posedge WCLK);
    #1;
    acc_cyc = cyc;
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
  endtask

  task automatic test_reset();
    WNRST = 1'b1;
    #12;
    checks++;
    if (W_EN !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b want 0", W_EN); end
    checks++;
    if (W_DI !== '0) begin errors++; $display("FAIL reset_wdi: got %h want 0", W_DI); end
    checks++;
    if (S_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", S_READY); end
`ifdef PACK_STATS_EN
    checks++;
    if (WORD_CNT !== 16'd0 || PAD_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", WORD_CNT, PAD_CNT);
    end
`endif
    @(posedge WCLK);
    #1;
    WNRST = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_full_word();
    int n;
    clear_log();
    drive_beat(8'h11, 1'b0);
    drive_beat(8'h22, 1'b0);
    drive_beat(8'h33, 1'b0);
    drive_beat(8'h44, 1'b0);
    n = acc_cyc;
    wait_cycles(4);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL word_count: got %0d writes want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 32'h44332211) begin
        errors++; $display("FAIL word_data: got %h want 44332211", got_data[0]);
      end
      checks++;
      if (got_cyc[0] != n) begin
        errors++; $display("FAIL word_latency: write in cycle %0d want %0d", got_cyc[0], n);
      end
    end
  endtask

  task automatic test_last();
    clear_log();
    drive_beat(8'hAA, 1'b0);
    drive_beat(8'hBB, 1'b1);
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    drive_beat(8'h03, 1'b0);
    drive_beat(8'h04, 1'b0);
    wait_cycles(4);
    checks++;
    if (got_data.size() != 2) begin
      errors++; $display("FAIL last_count: got %0d writes want 2", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 32'h0000BBAA) begin
        errors++; $display("FAIL last_data: got %h want 0000bbaa", got_data[0]);
      end
      checks++;
      if (got_data[1] !== 32'h04030201) begin
        errors++; $display("FAIL last_next_lane0: got %h want 04030201", got_data[1]);
      end
    end
  endtask

  task automatic test_full_stall();
    clear_log();
    drive_beat(8'hC1, 1'b0);
    drive_beat(8'hC2, 1'b0);
    drive_beat(8'hC3, 1'b0);
    drive_beat(8'hC4, 1'b0);
    FULL = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge WCLK);
      checks++;
      if (W_EN !== 1'b0 || S_READY !== 1'b0 || W_DI !== 32'hC4C3C2C1) begin
        errors++;
        $display("FAIL stall_cycle%0d: wen=%0b rdy=%0b wdi=%h want 0/0/c4c3c2c1",
                 i, W_EN, S_READY, W_DI);
      end
    end
    @(posedge WCLK);
    #1;
    FULL = 1'b0;
    wait_cycles(4);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL stall_release_count: got %0d writes want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 32'hC4C3C2C1) begin
        errors++; $display("FAIL stall_release_data: got %h want c4c3c2c1", got_data[0]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
`ifdef PACK_STATS_EN
    logic [15:0] pad0;
    pad0 = PAD_CNT;
`endif
    clear_log();
    drive_beat(8'h5A, 1'b0);
    n = acc_cyc;
    wait_cycles(2 * TO + 4);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL timeout_count: got %0d writes want 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 32'h0000005A) begin
        errors++; $display("FAIL timeout_data: got %h want 0000005a", got_data[0]);
      end
      checks++;
      if (got_cyc[0] != n + int'(TO) + 1) begin
        errors++;
        $display("FAIL timeout_latency: write in cycle %0d want %0d", got_cyc[0], n + TO + 1);
      end
    end
`ifdef PACK_STATS_EN
    checks++;
    if (PAD_CNT !== pad0 + 16'd1) begin
      errors++; $display("FAIL timeout_padcnt: got %0d want %0d", PAD_CNT, pad0 + 16'd1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] w;
`ifdef PACK_STATS_EN
    logic [15:0] wc0;
    wc0 = WORD_CNT;
`endif
    clear_log();
    for (int i = 0; i < 64; i++) drive_beat(IW'(i), 1'b0);
    wait_cycles(4);
    checks++;
    if (got_data.size() != 16) begin
      errors++; $display("FAIL stream_count: got %0d writes want 16", got_data.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        w = '0;
        for (int j = 0; j < int'(RATIO); j++) w = w | (OW'(4 * k + j) << (IW * j));
        checks++;
        if (got_data[k] !== w) begin
          errors++; $display("FAIL stream_word%0d: got %h want %h", k, got_data[k], w);
        end
        if (k > 0) begin
          checks++;
          if (got_cyc[k] - got_cyc[k-1] != int'(RATIO)) begin
            errors++;
            $display("FAIL stream_spacing%0d: got %0d want %0d", k,
                     got_cyc[k] - got_cyc[k-1], RATIO);
          end
        end
      end
    end
`ifdef PACK_STATS_EN
    checks++;
    if (WORD_CNT !== wc0 + 16'd16) begin
      errors++; $display("FAIL stream_wordcnt: got %0d want %0d", WORD_CNT, wc0 + 16'd16);
    end
`endif
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] word;
    logic [IW-1:0] d;
    logic          last;
    int            k = 0;
    int            nbeats = 200;
    clear_log();
    word = '0;
    for (int b = 0; b < nbeats; b++) begin
      // Gaps stay shorter than TIMEOUT so every word boundary comes from RATIO or S_LAST.
      repeat ($urandom_range(0, 3)) begin
        FULL = 1'($urandom % 2);
        @(posedge WCLK);
        #1;
      end
      FULL = 1'b0;
      d    = IW'($urandom);
      last = (b == nbeats - 1) || ($urandom % 5 == 0);
      drive_beat(d, last);
      word = word | (OW'(d) << (IW * k));
      k++;
      if (k == int'(RATIO) || last) begin
        exp_q.push_back(word);
        word = '0;
        k = 0;
      end
    end
    FULL = 1'b0;
    wait_cycles(6);
    checks++;
    if (got_data.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d writes want %0d", got_data.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_q[i]) begin
          errors++; $display("FAIL random_word%0d: got %h want %h", i, got_data[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    drive_beat(8'hE1, 1'b0);
    drive_beat(8'hE2, 1'b0);
    #1;
    WNRST = 1'b1;
    #1;
    checks++;
    if (W_EN !== 1'b0 || S_READY !== 1'b1 || W_DI !== '0) begin
      errors++;
      $display("FAIL midreset_state: wen=%0b rdy=%0b wdi=%h want 0/1/0", W_EN, S_READY, W_DI);
    end
    repeat (2) @(posedge WCLK);
    #1;
    WNRST = 1'b0;
    checks++;
    if (S_READY !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %0b want 1", S_READY); end
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    drive_beat(8'h03, 1'b0);
    drive_beat(8'h04, 1'b0);
    wait_cycles(4);
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'h04030201) begin
      errors++;
      $display("FAIL midreset_word: got %0d writes first %h want 1 write 04030201",
               got_data.size(), got_data[0]);
    end
    // A pending hold being written must vanish the instant reset asserts.
    FULL = 1'b1;
    drive_beat(8'h21, 1'b0);
    drive_beat(8'h22, 1'b0);
    drive_beat(8'h23, 1'b0);
    drive_beat(8'h24, 1'b0);
    FULL = 1'b0;
    #1;
    checks++;
    if (W_EN !== 1'b1) begin errors++; $display("FAIL pending_wen: got %0b want 1", W_EN); end
    WNRST = 1'b1;
    #1;
    checks++;
    if (W_EN !== 1'b0) begin errors++; $display("FAIL async_drop_wen: got %0b want 0", W_EN); end
    repeat (2) @(posedge WCLK);
    #1;
    WNRST = 1'b0;
    wait_cycles(4);
    checks++;
    if (got_data.size() != 1) begin
      errors++; $display("FAIL pending_discard: got %0d writes want 1", got_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last();
    test_full_stall();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
